// File: rtl/video_pkg.sv
// Shared types and default geometry for the video pixel shifter.
// The optional VIDEO_INVERSE_EN build relies on these same definitions.
package video_pkg;

   typedef enum logic [1:0] {
      VBLANK = 2'd0,
      TOP    = 2'd1,
      ACTIVE = 2'd2,
      BOTTOM = 2'd3
   } blank_state_t;

   localparam int ACTIVE_PIXELS_D = 512;
   localparam int TOP_LINES_D     = 16;
   localparam int ACTIVE_LINES_D  = 256;
   localparam int LINE_W_D        = 9;

endpackage

// File: rtl/video_blank_fsm.sv
// Frame/line blanking controller.
// It detects the line and frame trigger edges, counts pixels and lines, and
// walks VBLANK -> TOP -> ACTIVE -> BOTTOM. It reports when the display window is open.
module video_blank_fsm
   import video_pkg::*;
#(
   parameter int ACTIVE_PIXELS = ACTIVE_PIXELS_D,
   parameter int TOP_LINES     = TOP_LINES_D,
   parameter int ACTIVE_LINES  = ACTIVE_LINES_D,
   parameter int LINE_W        = LINE_W_D
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              trga_al,
   input  logic              vsync_al,
   input  logic              sft_al,
   output logic              blank_act,
   output logic              in_active,
   output logic [LINE_W-1:0] line_cnt
);

   // The pixel counter must be able to hold ACTIVE_PIXELS itself.
   localparam int PIX_W = $clog2(ACTIVE_PIXELS + 1);

   logic              trga_q;
   logic              vsync_q;
   logic              line_start;
   logic              frame_start;
   logic              h_active;
   logic [PIX_W-1:0]  pix_cnt;
   blank_state_t      state;
   blank_state_t      state_nxt;
   logic [LINE_W-1:0] line_nxt;

   // Remember the previous trigger levels so falling edges can be detected.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trga_q  <= 1'b1;
         vsync_q <= 1'b1;
      end else begin
         trga_q  <= trga_al;
         vsync_q <= vsync_al;
      end
   end

   assign line_start  = trga_q & ~trga_al;
   assign frame_start = vsync_q & ~vsync_al;

   // Count shift clocks within a line. The count restarts on each line and stops at the visible width.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_cnt <= '0;
      end else if (line_start) begin
         pix_cnt <= '0;
      end else if (!sft_al && (pix_cnt < PIX_W'(ACTIVE_PIXELS))) begin
         pix_cnt <= pix_cnt + 1'b1;
      end
   end

   assign h_active = (pix_cnt < PIX_W'(ACTIVE_PIXELS));

   // Vertical state and line counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= VBLANK;
         line_cnt <= '0;
      end else begin
         state    <= state_nxt;
         line_cnt <= line_nxt;
      end
   end

   // Vertical sequencing. A frame start overrides a line start in the same cycle.
   always_comb begin
      state_nxt = state;
      line_nxt  = line_cnt;
      if (frame_start) begin
         state_nxt = TOP;
         line_nxt  = '0;
      end else if (line_start) begin
         case (state)
            TOP: begin
               line_nxt = line_cnt + LINE_W'(1);
               if (line_nxt == LINE_W'(TOP_LINES)) begin
                  state_nxt = ACTIVE;
                  line_nxt  = '0;
               end
            end
            ACTIVE: begin
               line_nxt = line_cnt + LINE_W'(1);
               if (line_nxt == LINE_W'(ACTIVE_LINES)) begin
                  state_nxt = BOTTOM;
               end
            end
            default: begin
               state_nxt = state;
            end
         endcase
      end
   end

   // Open the display window only in active lines and before the pixel limit.
   always_comb begin
      in_active = (state == ACTIVE);
      blank_act = in_active & h_active;
   end

endmodule

// File: rtl/video_pixel_shifter.sv
// Video pixel shifter. It serialises the VD byte MSB-first and gates the result with
// the blanking window. It also produces registered BLANK_AL, CSYNC_AL and LINE_NUM.
// Optional build macro VIDEO_INVERSE_EN adds the REVERSE_AL input. REVERSE_AL is captured per byte and inverts the active pixels.
module video_pixel_shifter
   import video_pkg::*;
#(
   parameter int ACTIVE_PIXELS = ACTIVE_PIXELS_D,
   parameter int TOP_LINES     = TOP_LINES_D,
   parameter int ACTIVE_LINES  = ACTIVE_LINES_D,
   parameter int LINE_W        = LINE_W_D
) (
   input  logic              CLOCK_10MHZ,
   input  logic              RESET,
   input  logic              LD_SFT_AL,
   input  logic              SFT_AL,
   input  logic [7:0]        VD,
   input  logic              TRGA_AL,
   input  logic              VSYNC_AL,
`ifdef VIDEO_INVERSE_EN
   input  logic              REVERSE_AL,
`endif
   output logic              PIXEL_OUT,
   output logic              BLANK_AL,
   output logic              CSYNC_AL,
   output logic [LINE_W-1:0] LINE_NUM
);

   logic [7:0]        shreg;
   logic              pix_bit;
   logic              blank_act;
   logic              in_active;
   logic [LINE_W-1:0] line_cnt;

   video_blank_fsm #(
      .ACTIVE_PIXELS (ACTIVE_PIXELS),
      .TOP_LINES     (TOP_LINES),
      .ACTIVE_LINES  (ACTIVE_LINES),
      .LINE_W        (LINE_W)
   ) u_fsm (
      .clk       (CLOCK_10MHZ),
      .rst       (RESET),
      .trga_al   (TRGA_AL),
      .vsync_al  (VSYNC_AL),
      .sft_al    (SFT_AL),
      .blank_act (blank_act),
      .in_active (in_active),
      .line_cnt  (line_cnt)
   );

   // Parallel load or shift the pixel byte. Load wins when both are requested.
   always_ff @(posedge CLOCK_10MHZ or posedge RESET) begin
      if (RESET) begin
         shreg <= 8'h00;
      end else if (!LD_SFT_AL) begin
         shreg <= VD;
      end else if (!SFT_AL) begin
         shreg <= {shreg[6:0], 1'b0};
      end
   end

`ifdef VIDEO_INVERSE_EN
   logic rev_q;

   // Capture the reverse-video attribute with its byte so it applies per character cell.
   always_ff @(posedge CLOCK_10MHZ or posedge RESET) begin
      if (RESET) begin
         rev_q <= 1'b1;
      end else if (!LD_SFT_AL) begin
         rev_q <= REVERSE_AL;
      end
   end

   assign pix_bit = shreg[7] ^ ~rev_q;
`else
   assign pix_bit = shreg[7];
`endif

   // Output stage: one register after the shifter and the blanking state.
   always_ff @(posedge CLOCK_10MHZ or posedge RESET) begin
      if (RESET) begin
         PIXEL_OUT <= 1'b0;
         BLANK_AL  <= 1'b0;
         CSYNC_AL  <= 1'b1;
         LINE_NUM  <= '0;
      end else begin
         PIXEL_OUT <= pix_bit & blank_act;
         BLANK_AL  <= blank_act;
         CSYNC_AL  <= TRGA_AL & VSYNC_AL;
         LINE_NUM  <= in_active ? line_cnt : '0;
      end
   end

endmodule

// File: tb/tb_video_pixel_shifter.sv
// Directed bench for video_pixel_shifter at default geometry
// (512 pixels, 16 top lines, 256 active lines).
module tb_video_pixel_shifter;
   import video_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       ld_sft_al;
   logic       sft_al;
   logic [7:0] vd;
   logic       trga_al;
   logic       vsync_al;
   logic       reverse_al;
   logic       pixel_out;
   logic       blank_al;
   logic       csync_al;
   logic [8:0] line_num;

   int errors = 0;
   int checks = 0;

   always #50 clk = ~clk;

   video_pixel_shifter dut (
      .CLOCK_10MHZ (clk),
      .RESET       (rst),
      .LD_SFT_AL   (ld_sft_al),
      .SFT_AL      (sft_al),
      .VD          (vd),
      .TRGA_AL     (trga_al),
      .VSYNC_AL    (vsync_al),
`ifdef VIDEO_INVERSE_EN
      .REVERSE_AL  (reverse_al),
`endif
      .PIXEL_OUT   (pixel_out),
      .BLANK_AL    (blank_al),
      .CSYNC_AL    (csync_al),
      .LINE_NUM    (line_num)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic line_pulse;
      trga_al = 1'b0;
      tick();
      trga_al = 1'b1;
      tick();
   endtask

   task automatic frame_pulse;
      vsync_al = 1'b0;
      tick();
      vsync_al = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      rst = 1'b1; ld_sft_al = 1'b1; sft_al = 1'b1; vd = 8'h00;
      trga_al = 1'b1; vsync_al = 1'b1; reverse_al = 1'b1;
      #1;
      checks++; if (pixel_out !== 1'b0) begin errors++; $display("FAIL reset_pixel: got %b want 0", pixel_out); end
      checks++; if (blank_al !== 1'b0) begin errors++; $display("FAIL reset_blank: got %b want 0", blank_al); end
      checks++; if (csync_al !== 1'b1) begin errors++; $display("FAIL reset_csync: got %b want 1", csync_al); end
      checks++; if (line_num !== 9'd0) begin errors++; $display("FAIL reset_line: got %0d want 0", line_num); end
      tick(2);
      rst = 1'b0;
      tick(2);
      checks++; if (blank_al !== 1'b0) begin errors++; $display("FAIL vblank_idle: got %b want 0", blank_al); end
   endtask

   task automatic test_frame;
      vsync_al = 1'b0;
      tick();
      checks++; if (csync_al !== 1'b0) begin errors++; $display("FAIL frame_csync_low: got %b want 0", csync_al); end
      vsync_al = 1'b1;
      tick();
      checks++; if (csync_al !== 1'b1) begin errors++; $display("FAIL frame_csync_high: got %b want 1", csync_al); end
      repeat (15) line_pulse();
      checks++; if (blank_al !== 1'b0) begin errors++; $display("FAIL top_line15: got %b want 0", blank_al); end
      line_pulse();
      checks++; if (blank_al !== 1'b1) begin errors++; $display("FAIL line17_active: got %b want 1", blank_al); end
      checks++; if (line_num !== 9'd0) begin errors++; $display("FAIL line17_num: got %0d want 0", line_num); end
      line_pulse();
      checks++; if (line_num !== 9'd1) begin errors++; $display("FAIL line18_num: got %0d want 1", line_num); end
   endtask

   task automatic test_serial;
      logic [7:0] pat;
      pat = 8'hA5;
      vd = pat; ld_sft_al = 1'b0;
      tick();
      ld_sft_al = 1'b1; sft_al = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (pixel_out !== pat[7-i]) begin
            errors++; $display("FAIL serial_bit%0d: got %b want %b", i, pixel_out, pat[7-i]);
         end
      end
      sft_al = 1'b1;
   endtask

   task automatic test_collision;
      vd = 8'h80; ld_sft_al = 1'b0; sft_al = 1'b0;
      tick();
      ld_sft_al = 1'b1; sft_al = 1'b1;
      tick();
      checks++; if (pixel_out !== 1'b1) begin errors++; $display("FAIL collision_first: got %b want 1", pixel_out); end
      tick();
      checks++; if (pixel_out !== 1'b1) begin errors++; $display("FAIL collision_hold: got %b want 1", pixel_out); end
      vd = 8'h00; ld_sft_al = 1'b0;
      tick();
      ld_sft_al = 1'b1;
   endtask

   task automatic test_hblank;
      int highs;
      int first_low;
      highs = 0; first_low = 0;
      line_pulse();
      sft_al = 1'b0;
      for (int n = 1; n <= 600; n++) begin
         tick();
         if (blank_al === 1'b1) highs++;
         else if (first_low == 0) first_low = n;
      end
      sft_al = 1'b1;
      checks++; if (highs != 512) begin errors++; $display("FAIL hblank_high_count: got %0d want 512", highs); end
      checks++; if (first_low != 513) begin errors++; $display("FAIL hblank_first_low: got %0d want 513", first_low); end
      checks++; if (dut.u_fsm.pix_cnt !== 10'd512) begin errors++; $display("FAIL pix_saturate: got %0d want 512", dut.u_fsm.pix_cnt); end
   endtask

   task automatic test_bottom;
      repeat (253) line_pulse();
      checks++; if (blank_al !== 1'b1) begin errors++; $display("FAIL last_active_blank: got %b want 1", blank_al); end
      checks++; if (line_num !== 9'd255) begin errors++; $display("FAIL last_active_num: got %0d want 255", line_num); end
      line_pulse();
      checks++; if (blank_al !== 1'b0) begin errors++; $display("FAIL bottom_blank: got %b want 0", blank_al); end
      checks++; if (line_num !== 9'd0) begin errors++; $display("FAIL bottom_num: got %0d want 0", line_num); end
      vd = 8'hFF; ld_sft_al = 1'b0;
      tick();
      ld_sft_al = 1'b1;
      tick();
      checks++; if (pixel_out !== 1'b0) begin errors++; $display("FAIL bottom_pixel_gated: got %b want 0", pixel_out); end
      repeat (3) line_pulse();
      checks++; if (blank_al !== 1'b0) begin errors++; $display("FAIL bottom_hold: got %b want 0", blank_al); end
   endtask

   task automatic test_simultaneous;
      frame_pulse();
      repeat (5) line_pulse();
      checks++; if (csync_al !== 1'b1) begin errors++; $display("FAIL simul_csync_before: got %b want 1", csync_al); end
      trga_al = 1'b0; vsync_al = 1'b0;
      tick();
      checks++; if (dut.u_fsm.state !== TOP) begin errors++; $display("FAIL simul_state: got %0d want %0d", dut.u_fsm.state, TOP); end
      checks++; if (dut.u_fsm.line_cnt !== 9'd0) begin errors++; $display("FAIL simul_line_cnt: got %0d want 0", dut.u_fsm.line_cnt); end
      checks++; if (csync_al !== 1'b0) begin errors++; $display("FAIL simul_csync: got %b want 0", csync_al); end
      trga_al = 1'b1; vsync_al = 1'b1;
      tick();
      repeat (15) line_pulse();
      checks++; if (blank_al !== 1'b0) begin errors++; $display("FAIL simul_top15: got %b want 0", blank_al); end
      line_pulse();
      checks++; if (blank_al !== 1'b1) begin errors++; $display("FAIL simul_active: got %b want 1", blank_al); end
   endtask

   task automatic test_reset_mid;
      line_pulse();
      vd = 8'hFF; ld_sft_al = 1'b0;
      tick();
      ld_sft_al = 1'b1; sft_al = 1'b0; trga_al = 1'b0;
      tick();
      checks++; if (pixel_out !== 1'b1) begin errors++; $display("FAIL pre_reset_pixel: got %b want 1", pixel_out); end
      checks++; if (blank_al !== 1'b1) begin errors++; $display("FAIL pre_reset_blank: got %b want 1", blank_al); end
      checks++; if (csync_al !== 1'b0) begin errors++; $display("FAIL pre_reset_csync: got %b want 0", csync_al); end
      checks++; if (line_num !== 9'd1) begin errors++; $display("FAIL pre_reset_line: got %0d want 1", line_num); end
      #10 rst = 1'b1;
      #1;
      checks++; if (pixel_out !== 1'b0) begin errors++; $display("FAIL mid_reset_pixel: got %b want 0", pixel_out); end
      checks++; if (blank_al !== 1'b0) begin errors++; $display("FAIL mid_reset_blank: got %b want 0", blank_al); end
      checks++; if (csync_al !== 1'b1) begin errors++; $display("FAIL mid_reset_csync: got %b want 1", csync_al); end
      checks++; if (line_num !== 9'd0) begin errors++; $display("FAIL mid_reset_line: got %0d want 0", line_num); end
      tick(2);
      rst = 1'b0; trga_al = 1'b1; sft_al = 1'b1;
      tick();
      repeat (2) line_pulse();
      checks++; if (blank_al !== 1'b0) begin errors++; $display("FAIL post_reset_blank: got %b want 0", blank_al); end
      frame_pulse();
      repeat (16) line_pulse();
      checks++; if (blank_al !== 1'b1) begin errors++; $display("FAIL post_reset_recover: got %b want 1", blank_al); end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_serial();
      test_collision();
      test_hblank();
      test_bottom();
      test_simultaneous();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
